spi_ctrl_seq: RTL and testbench

Transfer sequencer for the SPI peripheral. It watches the 32-bit SPI control register and, when software sets the send bit, runs the requested number of byte transfers. For each byte it reads the TX buffer, drives the shift engine and stores the received byte in the RX buffer. It writes progress and completion back into the control register through the register's priority write port (wr_2_i/in_2_i), so software sees a self-clearing send bit.

---
 rtl/spi_ctrl_seq.sv | 185 ++++++++++++++++++
 tb/tb_spi_ctrl_seq.sv | 320 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_ctrl_seq.sv
// spi_ctrl_seq: byte-burst sequencer for the SPI peripheral.
// Watches the control register's send bit, walks the TX buffer through the
// shift engine, stores received bytes in the RX buffer, and writes progress
// and completion back through the control register's priority write port.
module spi_ctrl_seq #(
   parameter int AW = 9,
   parameter int DW = 8
) (
   input  logic          clk_i,
   input  logic          rst_i,
   input  logic [31:0]   ctrl_i,
   output logic          ctrl_wr_o,
   output logic [31:0]   ctrl_data_o,
   output logic [AW-1:0] buf_addr_o,
   input  logic [DW-1:0] tx_data_i,
   output logic          rx_we_o,
   output logic [DW-1:0] rx_data_o,
   output logic          spi_start_o,
   output logic [DW-1:0] spi_tx_o,
   input  logic          spi_done_i,
   input  logic [DW-1:0] spi_rx_i,
   output logic          cs_n_o,
   output logic          busy_o
);

   // Control register field layout.
   localparam int SEND_BIT = 0;
   localparam int ALL1_BIT = 1;
   localparam int ALL0_BIT = 2;
   localparam int NTX_LSB  = 4;
   localparam int NRX_LSB  = 16;
   localparam int FIELD_W  = 9;

   typedef enum logic [2:0] {
      S_IDLE,
      S_RD_TX,
      S_LOAD,
      S_WAIT,
      S_STORE,
      S_DONE
   } state_t;

   state_t        state_q, state_d;
   logic [31:0]   ctrl_q, ctrl_d;
   logic [AW-1:0] cnt_q, cnt_d;
   logic [AW-1:0] addr_q, addr_d;
   logic [DW-1:0] tx_q, tx_d;
   logic [DW-1:0] rx_q, rx_d;
   logic [31:0]   wb_q, wb_d;
   logic          wr_q, wr_d;
   logic          we_q, we_d;
   logic          start_q, start_d;
   logic          cs_n_q, cs_n_d;
   logic          busy_q, busy_d;

   logic [AW-1:0] n_tx_end;
   logic          last_byte;
   logic [31:0]   wb_value;

   // Burst length comes from the copy latched at start, so software writes
   // to the live register during a burst cannot shorten or extend it.
   assign n_tx_end  = ctrl_q[NTX_LSB +: AW];
   assign last_byte = (cnt_q == n_tx_end);

   // Write-back word: latched control value with progress and send status.
   always_comb begin
      wb_value = ctrl_q;
      wb_value[NRX_LSB +: FIELD_W] = FIELD_W'(cnt_q);
      wb_value[SEND_BIT] = ~last_byte;
   end

   // Next-state and next-output logic; every output is registered.
   always_comb begin
      // NOTE: every signal gets a default before the case so no path leaves
      // one unassigned, which would otherwise infer a latch.
      state_d = state_q;
      ctrl_d  = ctrl_q;
      cnt_d   = cnt_q;
      addr_d  = addr_q;
      tx_d    = tx_q;
      rx_d    = rx_q;
      wb_d    = wb_q;
      wr_d    = 1'b0;
      we_d    = 1'b0;
      start_d = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (ctrl_i[SEND_BIT]) begin
               ctrl_d  = ctrl_i;
               cnt_d   = '0;
               addr_d  = '0;
               state_d = S_RD_TX;
            end
         end
         S_RD_TX: begin
            // The buffer address is already presented; read data arrives next cycle.
            state_d = S_LOAD;
         end
         S_LOAD: begin
            if (ctrl_q[ALL1_BIT]) begin
               tx_d = {DW{1'b1}};
            end else if (ctrl_q[ALL0_BIT]) begin
               tx_d = '0;
            end else begin
               tx_d = tx_data_i;
            end
            start_d = 1'b1;
            state_d = S_WAIT;
         end
         S_WAIT: begin
            if (spi_done_i) begin
               rx_d    = spi_rx_i;
               we_d    = 1'b1;
               wr_d    = 1'b1;
               wb_d    = wb_value;
               state_d = S_STORE;
            end
         end
         S_STORE: begin
            if (last_byte) begin
               state_d = S_DONE;
            end else begin
               cnt_d   = cnt_q + 1'b1;
               addr_d  = cnt_q + 1'b1;
               state_d = S_RD_TX;
            end
         end
         S_DONE: begin
            // One dead cycle so the stale send bit is not seen while the clear lands.
            state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase

      // Chip select and busy follow the state being entered, so they are
      // registered yet still change in the first cycle of that state.
      cs_n_d = (state_d == S_IDLE) || (state_d == S_DONE);
      busy_d = ~cs_n_d;
   end

   // State and output registers with synchronous reset.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q <= S_IDLE;
         ctrl_q  <= '0;
         cnt_q   <= '0;
         addr_q  <= '0;
         tx_q    <= '0;
         rx_q    <= '0;
         wb_q    <= '0;
         wr_q    <= 1'b0;
         we_q    <= 1'b0;
         start_q <= 1'b0;
         cs_n_q  <= 1'b1;
         busy_q  <= 1'b0;
      end else begin
         // NOTE: non-blocking assignments so every register samples the values
         // from before this edge, independent of statement order.
         state_q <= state_d;
         ctrl_q  <= ctrl_d;
         cnt_q   <= cnt_d;
         addr_q  <= addr_d;
         tx_q    <= tx_d;
         rx_q    <= rx_d;
         wb_q    <= wb_d;
         wr_q    <= wr_d;
         we_q    <= we_d;
         start_q <= start_d;
         cs_n_q  <= cs_n_d;
         busy_q  <= busy_d;
      end
   end

   assign ctrl_wr_o   = wr_q;
   assign ctrl_data_o = wb_q;
   assign buf_addr_o  = addr_q;
   assign rx_we_o     = we_q;
   assign rx_data_o   = rx_q;
   assign spi_start_o = start_q;
   assign spi_tx_o    = tx_q;
   assign cs_n_o      = cs_n_q;
   assign busy_o      = busy_q;

endmodule

// File: tb/tb_spi_ctrl_seq.sv
// Testbench for spi_ctrl_seq: control register, TX buffer and shift engine
// models around the DUT; expected bytes and write-backs go into queues when a
// burst is issued and a separate monitor pops and compares on each DUT event.
module tb_spi_ctrl_seq;

   localparam int AW = 9;
   localparam int DW = 8;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic [31:0]   ctrl_reg;
   logic          ctrl_wr;
   logic [31:0]   ctrl_data;
   logic [AW-1:0] buf_addr;
   logic [DW-1:0] tx_data;
   logic          rx_we;
   logic [DW-1:0] rx_data;
   logic          spi_start;
   logic [DW-1:0] spi_tx;
   logic          spi_done;
   logic [DW-1:0] spi_rx;
   logic          cs_n;
   logic          busy;

   logic          eng_done  = 1'b0;
   logic          spur_done = 1'b0;
   logic [DW-1:0] eng_rx    = '0;
   logic          sw_wr     = 1'b0;
   logic [31:0]   sw_data   = '0;

   logic [DW-1:0] tx_mem [0:511];

   int chk_cnt  = 0;
   int pass_cnt = 0;

   // Scoreboard queues (expected DUT events) and engine stimulus queues.
   logic [DW-1:0] exp_start_q[$];
   logic [31:0]   exp_rx_q[$];
   logic [31:0]   exp_wr_q[$];
   logic [DW-1:0] resp_q[$];
   int            lat_q[$];

   always #50 clk = ~clk;

   assign spi_done = eng_done | spur_done;
   assign spi_rx   = eng_rx;

   spi_ctrl_seq #(.AW(AW), .DW(DW)) dut (
      .clk_i       (clk),
      .rst_i       (rst),
      .ctrl_i      (ctrl_reg),
      .ctrl_wr_o   (ctrl_wr),
      .ctrl_data_o (ctrl_data),
      .buf_addr_o  (buf_addr),
      .tx_data_i   (tx_data),
      .rx_we_o     (rx_we),
      .rx_data_o   (rx_data),
      .spi_start_o (spi_start),
      .spi_tx_o    (spi_tx),
      .spi_done_i  (spi_done),
      .spi_rx_i    (spi_rx),
      .cs_n_o      (cs_n),
      .busy_o      (busy)
   );

   // Control register: the priority port beats software writes.
   always @(posedge clk) begin
      if (rst)          ctrl_reg <= '0;
      else if (ctrl_wr) ctrl_reg <= ctrl_data;
      else if (sw_wr)   ctrl_reg <= sw_data;
   end

   // TX buffer with synchronous read.
   always @(posedge clk) tx_data <= tx_mem[buf_addr];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      chk_cnt++;
      if (act === exp) pass_cnt++;
      else $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
   endtask

   // Byte put on the wire for a given control word and buffer byte.
   function automatic logic [DW-1:0] model_byte(input logic [31:0] c, input logic [DW-1:0] t);
      if (c[1]) return 8'hFF;
      if (c[2]) return 8'h00;
      return t;
   endfunction

   // Control write-back after byte i of an n-byte burst.
   function automatic logic [31:0] model_wb(input logic [31:0] c, input int i, input int n);
      logic [31:0] w;
      w = (c & ~32'h01FF_0001) | (32'(i) << 16);
      if (i != n - 1) w = w | 32'h1;
      return w;
   endfunction

   // Monitor: every DUT start, RX write and control write is matched to the scoreboard.
   always @(negedge clk) begin : monitor
      logic [31:0] e;
      if (spi_start === 1'b1) begin
         if (exp_start_q.size() == 0) check("start_unexpected", 32'(spi_start), 32'h0);
         else begin
            e = 32'(exp_start_q.pop_front());
            check("spi_tx_byte", 32'(spi_tx), e);
         end
      end
      if (rx_we === 1'b1) begin
         if (exp_rx_q.size() == 0) check("rx_we_unexpected", 32'(rx_we), 32'h0);
         else begin
            e = exp_rx_q.pop_front();
            check("rx_write", {15'b0, buf_addr, rx_data}, e);
         end
      end
      if (ctrl_wr === 1'b1) begin
         if (exp_wr_q.size() == 0) check("ctrl_wr_unexpected", 32'(ctrl_wr), 32'h0);
         else begin
            e = exp_wr_q.pop_front();
            check("ctrl_writeback", ctrl_data, e);
         end
      end
   end

   // Shift engine: on each start, wait the queued latency and return the queued byte.
   initial begin : engine
      logic [DW-1:0] r, sent;
      int lat;
      forever begin
         @(negedge clk);
         if (spi_start === 1'b1) begin
            sent = spi_tx;
            r    = (resp_q.size() != 0) ? resp_q.pop_front() : '0;
            lat  = (lat_q.size() != 0) ? lat_q.pop_front() : 2;
            repeat (lat - 1) @(negedge clk);
            if (busy === 1'b1) check("spi_tx_stable", 32'(spi_tx), 32'(sent));
            eng_done = 1'b1;
            eng_rx   = r;
            @(negedge clk);
            eng_done = 1'b0;
         end
      end
   end

   // One burst: queue expectations, write send, check timing, wait for completion.
   // rmode: 0 random response, 1 loopback, 2 fixed response fix_rx.
   task automatic run_burst(input string tag, input logic [31:0] cval, input int lat_min,
                            input int lat_max, input int rmode, input logic [DW-1:0] fix_rx,
                            input bit spur_en, input bit mid_en);
      int n, cyc, wr_seen, starts, post_wr, lat;
      bit cs_hi;
      logic [DW-1:0] b, r;
      logic [8:0] a;
      logic [31:0] last_wb;
      n = int'(cval[12:4]) + 1;
      for (int i = 0; i < n; i++) begin
         b = model_byte(cval, tx_mem[i]);
         case (rmode)
            1:       r = b;
            2:       r = fix_rx;
            default: r = 8'($urandom_range(255, 0));
         endcase
         lat = int'($urandom_range(lat_max, lat_min));
         a = 9'(i);
         exp_start_q.push_back(b);
         resp_q.push_back(r);
         lat_q.push_back(lat);
         exp_rx_q.push_back({15'b0, a, r});
         exp_wr_q.push_back(model_wb(cval, i, n));
      end
      last_wb = model_wb(cval, n - 1, n);

      if (spur_en) begin
         @(negedge clk); spur_done = 1'b1;
         @(negedge clk); spur_done = 1'b0;
         @(negedge clk);
         check({tag, "_idle_after_spurious"}, 32'(cs_n), 32'h1);
      end

      @(negedge clk); sw_wr = 1'b1; sw_data = cval;
      @(negedge clk); sw_wr = 1'b0;
      check({tag, "_cs_n_at_send"}, 32'(cs_n), 32'h1);
      cyc = 0;
      do begin
         @(negedge clk);
         cyc++;
         if (cyc == 1) check({tag, "_cs_n_fall"}, 32'(cs_n), 32'h0);
      end while (spi_start !== 1'b1 && cyc < 10);
      check({tag, "_start_latency"}, 32'(cyc), 32'd3);

      starts  = (spi_start === 1'b1) ? 1 : 0;
      wr_seen = 0;
      post_wr = 0;
      cs_hi   = 1'b0;
      cyc     = 0;
      while (wr_seen < n && cyc < n * (lat_max + 12) + 20) begin
         @(negedge clk);
         cyc++;
         if (spi_start === 1'b1) starts++;
         if (ctrl_wr === 1'b1) begin
            wr_seen++;
            post_wr = 1;
         end else if (post_wr > 0) begin
            post_wr++;
         end
         if (cs_n !== 1'b0) cs_hi = 1'b1;
         // post_wr==2 is the RD_TX cycle of the next byte.
         spur_done = spur_en && (post_wr == 2) && (wr_seen < n);
         sw_wr     = mid_en && (post_wr == 2) && (wr_seen == 1);
         sw_data   = {cval[31:13], 9'd1, cval[3:0]};
      end
      spur_done = 1'b0;
      sw_wr     = 1'b0;
      check({tag, "_writebacks"}, 32'(wr_seen), 32'(n));
      check({tag, "_starts"}, 32'(starts), 32'(n));
      check({tag, "_cs_low_in_burst"}, 32'(cs_hi), 32'h0);
      @(negedge clk);
      check({tag, "_cs_n_rise"}, 32'(cs_n), 32'h1);
      check({tag, "_busy_clear"}, 32'(busy), 32'h0);
      repeat (4) @(negedge clk);
      check({tag, "_ctrl_reg_final"}, ctrl_reg, last_wb);
      check({tag, "_scoreboard_empty"},
            32'(exp_start_q.size() + exp_rx_q.size() + exp_wr_q.size()), 32'h0);
   endtask

   // Reset while waiting on the second byte of a 4-byte burst.
   task automatic run_reset_test();
      int cyc, starts;
      logic [DW-1:0] r;
      for (int i = 0; i < 4; i++) tx_mem[i] = 8'($urandom_range(255, 0));
      for (int i = 0; i < 2; i++) begin
         r = 8'($urandom_range(255, 0));
         exp_start_q.push_back(tx_mem[i]);
         resp_q.push_back(r);
         lat_q.push_back(i == 0 ? 3 : 20);
         if (i == 0) begin
            exp_rx_q.push_back({15'b0, 9'd0, r});
            exp_wr_q.push_back(model_wb(32'h0000_0031, 0, 4));
         end
      end
      @(negedge clk); sw_wr = 1'b1; sw_data = 32'h0000_0031;
      @(negedge clk); sw_wr = 1'b0;
      starts = 0;
      cyc    = 0;
      while (starts < 2 && cyc < 100) begin
         @(negedge clk);
         cyc++;
         if (spi_start === 1'b1) starts++;
      end
      check("rst_reached_byte2", 32'(starts), 32'd2);
      repeat (4) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      check("rst_mid_cs_n", 32'(cs_n), 32'h1);
      check("rst_mid_busy", 32'(busy), 32'h0);
      rst = 1'b0;
      repeat (30) @(negedge clk);
      check("rst_mid_stays_idle", 32'(cs_n), 32'h1);
      check("rst_mid_scoreboard_empty",
            32'(exp_start_q.size() + exp_rx_q.size() + exp_wr_q.size()), 32'h0);
   endtask

   initial begin : watchdog
      #(100 * 60000);
      $display("FAIL watchdog: simulation did not finish, checks=%0d", chk_cnt);
      $fatal(1);
   end

   initial begin : stimulus
      logic [31:0] c;
      int n;
      for (int i = 0; i < 512; i++) tx_mem[i] = '0;
      rst = 1'b1;
      repeat (3) @(negedge clk);
      check("reset_cs_n", 32'(cs_n), 32'h1);
      check("reset_busy", 32'(busy), 32'h0);
      check("reset_strobes", {29'b0, ctrl_wr, rx_we, spi_start}, 32'h0);
      check("reset_buf_addr", 32'(buf_addr), 32'h0);
      check("reset_rx_data", 32'(rx_data), 32'h0);
      check("reset_spi_tx", 32'(spi_tx), 32'h0);
      check("reset_ctrl_data", ctrl_data, 32'h0);
      rst = 1'b0;
      repeat (2) @(negedge clk);

      // Single byte with a fixed engine response after 16 cycles.
      tx_mem[0] = 8'hA5;
      run_burst("single", 32'h0000_0001, 16, 16, 2, 8'h3C, 1'b0, 1'b0);

      // Four-byte loopback burst.
      tx_mem[0] = 8'h11; tx_mem[1] = 8'h22; tx_mem[2] = 8'h33; tx_mem[3] = 8'h44;
      run_burst("burst4", 32'h0000_0031, 1, 6, 1, 8'h00, 1'b0, 1'b0);

      // Data modes: all_1s wins over all_0s, then all_0s alone.
      tx_mem[0] = 8'h00;
      run_burst("all1s", 32'h0000_0007, 1, 4, 0, 8'h00, 1'b0, 1'b0);
      tx_mem[0] = 8'h5A;
      run_burst("all0s", 32'h0000_0005, 1, 4, 0, 8'h00, 1'b0, 1'b0);

      // Random control words: preserved upper bits, random length and mode.
      for (int k = 0; k < 4; k++) begin
         n = int'($urandom_range(8, 1));
         for (int i = 0; i < n; i++) tx_mem[i] = 8'($urandom_range(255, 0));
         c = ($urandom & ~32'h0000_1FF1) | (32'(n - 1) << 4) | 32'h1;
         run_burst("random", c, 1, 8, 0, 8'h00, 1'b0, 1'b0);
      end

      // Software write shortening n_tx_end mid-burst, then a fresh send.
      for (int i = 0; i < 6; i++) tx_mem[i] = 8'($urandom_range(255, 0));
      run_burst("sw_mid", 32'hA500_0051, 1, 5, 0, 8'h00, 1'b0, 1'b1);
      run_burst("rearm", 32'h0000_0011, 1, 5, 1, 8'h00, 1'b0, 1'b0);

      run_reset_test();

      // Maximum length with spurious done pulses in IDLE and RD_TX.
      for (int i = 0; i < 512; i++) tx_mem[i] = 8'($urandom_range(255, 0));
      run_burst("max_len", 32'h0000_1FF1, 1, 2, 0, 8'h00, 1'b1, 1'b0);

      $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
      $finish;
   end

endmodule
